// File: rtl/usb_tx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usb_tx_pkg : shared types and constants for the USB TX pipeline  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package usb_tx_pkg;

  localparam int USB_PID_BITS  = 8;
  localparam int USB_STUFF_LEN = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PID       = 3'd1,
    DATA      = 3'd2,
    STUFF     = 3'd3,
    STUFF_END = 3'd4
  } stuff_state_t;

endpackage
`default_nettype wire

// File: rtl/bit_stuffer_fsm.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bit_stuffer_fsm : stuffing control FSM and output registers      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bit_stuffer_fsm
  import usb_tx_pkg::*;
#(
  parameter int PID_BITS  = USB_PID_BITS,
  parameter int STUFF_LEN = USB_STUFF_LEN,
  parameter int PW        = $clog2(PID_BITS + 1),
  parameter int OW        = $clog2(STUFF_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_s_in,
  input  logic          i_start,
  input  logic          i_end,
  input  logic [PW-1:0] i_pid_cnt,
  input  logic [OW-1:0] i_ones_cnt,
  output logic          o_pid_en,
  output logic          o_pid_clr,
  output logic          o_ones_en,
  output logic          o_ones_clr,
  output logic          o_stall,
  output logic          o_s_out,
  output logic          o_out_valid,
  output logic          o_start_nrzi,
  output logic          o_end_nrzi
);

  stuff_state_t  r_cs, w_ns;
  logic          r_s_out, r_out_valid, r_start_nrzi, r_end_nrzi;
  logic          w_s_out, w_out_valid, w_start_nrzi, w_end_nrzi;
  logic [OW-1:0] w_ones_inc;

  assign w_ones_inc = i_ones_cnt + 1'b1;

  always_comb begin
    w_ns         = r_cs;
    w_s_out      = 1'b0;
    w_out_valid  = 1'b0;
    w_start_nrzi = 1'b0;
    w_end_nrzi   = 1'b0;
    o_pid_en     = 1'b0;
    o_pid_clr    = 1'b0;
    o_ones_en    = 1'b0;
    o_ones_clr   = 1'b0;
    unique case (r_cs)
      IDLE: begin
        o_ones_clr = 1'b1;
        if (i_start) begin
          w_s_out      = i_s_in;
          w_out_valid  = 1'b1;
          w_start_nrzi = 1'b1;
          if (i_end) begin
            w_end_nrzi = 1'b1;
            o_pid_clr  = 1'b1;
          end else begin
            o_pid_en = 1'b1;
            w_ns     = (PID_BITS == 1) ? DATA : PID;
          end
        end
      end
      PID: begin
        w_s_out     = i_s_in;
        w_out_valid = 1'b1;
        if (i_end) begin
          w_end_nrzi = 1'b1;
          o_pid_clr  = 1'b1;
          o_ones_clr = 1'b1;
          w_ns       = IDLE;
        end else begin
          // Counter saturates at PID_BITS because PID is left on that bit
          o_pid_en = 1'b1;
          if (i_pid_cnt == PW'(PID_BITS - 1)) begin
            w_ns = DATA;
          end
        end
      end
      DATA: begin
        w_s_out     = i_s_in;
        w_out_valid = 1'b1;
        o_ones_en   = i_s_in;
        o_ones_clr  = !i_s_in;
        if (i_s_in && (w_ones_inc == OW'(STUFF_LEN))) begin
          w_ns = i_end ? STUFF_END : STUFF;
        end else if (i_end) begin
          w_end_nrzi = 1'b1;
          o_pid_clr  = 1'b1;
          o_ones_clr = 1'b1;
          w_ns       = IDLE;
        end
      end
      STUFF: begin
        w_out_valid = 1'b1;
        o_ones_clr  = 1'b1;
        w_ns        = DATA;
      end
      STUFF_END: begin
        w_out_valid = 1'b1;
        w_end_nrzi  = 1'b1;
        o_ones_clr  = 1'b1;
        o_pid_clr   = 1'b1;
        w_ns        = IDLE;
      end
      default: begin
        w_ns = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs         <= IDLE;
      r_s_out      <= 1'b0;
      r_out_valid  <= 1'b0;
      r_start_nrzi <= 1'b0;
      r_end_nrzi   <= 1'b0;
    end else begin
      r_cs         <= w_ns;
      r_s_out      <= w_s_out;
      r_out_valid  <= w_out_valid;
      r_start_nrzi <= w_start_nrzi;
      r_end_nrzi   <= w_end_nrzi;
    end
  end

  assign o_stall      = (r_cs == STUFF);
  assign o_s_out      = r_s_out;
  assign o_out_valid  = r_out_valid;
  assign o_start_nrzi = r_start_nrzi;
  assign o_end_nrzi   = r_end_nrzi;

endmodule
`default_nettype wire

// File: rtl/counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | counter : generic up-counter with synchronous clear priority     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/bit_stuffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bit_stuffer : USB TX bit stuffer between CRC stage and NRZI      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module bit_stuffer
  import usb_tx_pkg::*;
#(
  parameter int PID_BITS  = USB_PID_BITS,
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_in,
  input  logic start_stuffer,
  input  logic end_stuffer,
  output logic stall,
  output logic s_out,
  output logic out_valid,
  output logic start_nrzi,
  output logic end_nrzi
);

  localparam int PW = $clog2(PID_BITS + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);

  logic [PW-1:0] w_pid_cnt;
  logic [OW-1:0] w_ones_cnt;
  logic          w_pid_en, w_pid_clr, w_ones_en, w_ones_clr;

  counter #(.W(PW)) u_pid_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_pid_en),
    .i_clr   (w_pid_clr),
    .o_count (w_pid_cnt)
  );

  counter #(.W(OW)) u_ones_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_ones_en),
    .i_clr   (w_ones_clr),
    .o_count (w_ones_cnt)
  );

  bit_stuffer_fsm #(
    .PID_BITS  (PID_BITS),
    .STUFF_LEN (STUFF_LEN),
    .PW        (PW),
    .OW        (OW)
  ) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_s_in       (s_in),
    .i_start      (start_stuffer),
    .i_end        (end_stuffer),
    .i_pid_cnt    (w_pid_cnt),
    .i_ones_cnt   (w_ones_cnt),
    .o_pid_en     (w_pid_en),
    .o_pid_clr    (w_pid_clr),
    .o_ones_en    (w_ones_en),
    .o_ones_clr   (w_ones_clr),
    .o_stall      (stall),
    .o_s_out      (s_out),
    .o_out_valid  (out_valid),
    .o_start_nrzi (start_nrzi),
    .o_end_nrzi   (end_nrzi)
  );

endmodule
`default_nettype wire

// File: tb/tb_bit_stuffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bit_stuffer : scoreboard bench for bit_stuffer                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_bit_stuffer;
  import usb_tx_pkg::*;

  typedef struct packed {
    logic b;
    logic st;
    logic en;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_in = 1'b0;
  logic start_stuffer = 1'b0;
  logic end_stuffer = 1'b0;
  logic stall, s_out, out_valid, start_nrzi, end_nrzi;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   stall_cnt = 0;
  int   cyc = 0;
  int   last_end_cyc = -100;
  int   start_gap = 0;
  int   exp_stalls;
  int   tmp_stalls;

  always #5 clk = ~clk;

  bit_stuffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_in          (s_in),
    .start_stuffer (start_stuffer),
    .end_stuffer   (end_stuffer),
    .stall         (stall),
    .s_out         (s_out),
    .out_valid     (out_valid),
    .start_nrzi    (start_nrzi),
    .end_nrzi      (end_nrzi)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] pid, input logic [31:0] data);
    return {24'b0, data, pid};
  endfunction

  // Reference: PID bits verbatim, then a 0 after every run of STUFF_LEN data ones
  task automatic build_expected(input logic [63:0] bits, input int n, input bit with_end,
                                output int stalls);
    int   run;
    bit   last;
    exp_t e;
    run    = 0;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      last = with_end && (i == n - 1);
      e.b  = bits[i];
      e.st = (i == 0);
      e.en = last;
      if (i >= USB_PID_BITS) begin
        run = bits[i] ? run + 1 : 0;
      end
      if (run == USB_STUFF_LEN) begin
        e.en = 1'b0;
        exp_q.push_back(e);
        e.b  = 1'b0;
        e.st = 1'b0;
        e.en = last;
        exp_q.push_back(e);
        if (!last) stalls++;
        run = 0;
      end else begin
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send(input logic [63:0] bits, input int n, input bit with_end, input int spur_idx);
    int   idx;
    int   guard;
    logic st;
    idx   = 0;
    guard = 0;
    while (idx < n) begin
      @(negedge clk);
      s_in          = bits[idx];
      start_stuffer = (idx == 0) || (idx == spur_idx);
      end_stuffer   = with_end && (idx == n - 1);
      #1 st = stall;
      @(posedge clk);
      if (!st) idx++;
      guard++;
      if (guard > 4 * n + 8) begin
        chk("drive_timeout", 32'(guard), 32'(0));
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_in          = 1'b0;
      start_stuffer = 1'b0;
      end_stuffer   = 1'b0;
    end
  endtask

  task automatic run_pkt(input string tag, input logic [63:0] bits, input int n, input int spur_idx);
    stall_cnt = 0;
    build_expected(bits, n, 1'b1, exp_stalls);
    send(bits, n, 1'b1, spur_idx);
    idle(3);
    #1;
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'(0));
    chk({tag, "_stalls"}, 32'(stall_cnt), 32'(exp_stalls));
    exp_q.delete();
  endtask

  always @(negedge clk) begin : mon
    cyc++;
    if (rst_n) begin
      if (stall) stall_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 32'(1), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("s_out", 32'(s_out), 32'(mon_e.b));
          chk("start_nrzi", 32'(start_nrzi), 32'(mon_e.st));
          chk("end_nrzi", 32'(end_nrzi), 32'(mon_e.en));
        end
        if (start_nrzi) start_gap = cyc - last_end_cyc;
        if (end_nrzi) last_end_cyc = cyc;
      end else if (start_nrzi || end_nrzi) begin
        chk("flag_without_valid", 32'({start_nrzi, end_nrzi}), 32'(0));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    #12;
    chk("rst_s_out", 32'(s_out), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_start_nrzi", 32'(start_nrzi), 32'(0));
    chk("rst_end_nrzi", 32'(end_nrzi), 32'(0));
    chk("rst_stall", 32'(stall), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // PID of all ones is not counted; six data ones get one stuffed 0
    run_pkt("pid_ff", mk(8'hFF, 32'b0111111), 15, -1);
    // Twelve data ones: one stalled stuff, one trailing stuff carrying end_nrzi
    run_pkt("twelve_ones", mk(8'hA5, 32'hFFF), 20, -1);
    // Runs under six: passes through unchanged
    run_pkt("short_runs", mk(8'h3C, 32'hBE), 16, -1);
    // Spurious start_stuffer mid-DATA is ignored
    run_pkt("spur_start", mk(8'h5A, 32'b010111111), 17, 15);

    // Back-to-back: 5 trailing ones must not carry into the next packet
    stall_cnt = 0;
    build_expected(mk(8'h3C, 32'b111110), 14, 1'b1, exp_stalls);
    build_expected(mk(8'h00, 32'b101), 11, 1'b1, tmp_stalls);
    exp_stalls += tmp_stalls;
    send(mk(8'h3C, 32'b111110), 14, 1'b1, -1);
    send(mk(8'h00, 32'b101), 11, 1'b1, -1);
    idle(3);
    #1;
    chk("b2b_drain", 32'(exp_q.size()), 32'(0));
    chk("b2b_stalls", 32'(stall_cnt), 32'(exp_stalls));
    chk("b2b_gap", 32'(start_gap), 32'(1));
    exp_q.delete();

    // Abort mid-DATA with four ones counted
    build_expected(mk(8'hFF, 32'b1111), 12, 1'b0, exp_stalls);
    send(mk(8'hFF, 32'b1111), 12, 1'b0, -1);
    @(negedge clk);
    s_in          = 1'b0;
    start_stuffer = 1'b0;
    end_stuffer   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_s_out", 32'(s_out), 32'(0));
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_start_nrzi", 32'(start_nrzi), 32'(0));
    chk("abort_end_nrzi", 32'(end_nrzi), 32'(0));
    chk("abort_stall", 32'(stall), 32'(0));
    chk("abort_drain", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    run_pkt("post_reset", mk(8'hFF, 32'b11111), 13, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
